// File: rtl/req_dispatch_pkg.sv
// req_dispatch_pkg: shared constants and state type for the request dispatcher.
//   N_REQ   number of request lines
//   ID_W    width of a request index
//   state_t dispatcher FSM state (ST_IDLE / ST_PRESENT)
package req_dispatch_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational lowest-index priority encoder.
//   eligible_i  in   8  candidate request bits
//   id_o        out  3  index of the lowest set bit (0 when none set)
//   any_o       out  1  at least one bit of eligible_i is set
module prio_enc8
    import req_dispatch_pkg::*;
(
    input  logic [N_REQ-1:0] eligible_i,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        id_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

    assign any_o = |eligible_i;

endmodule

// File: rtl/req_dispatch_8.sv
// req_dispatch_8: captures rising edges on eight request lines into a pending
// register and presents the lowest-index unmasked pending request as an ID on a
// valid/ready handshake.
//   clk        in   1      system clock
//   resetn     in   1      async active-low reset
//   req_i      in   8      request lines; 0->1 raises a request
//   mask_i     in   8      1 = line not selectable (capture continues)
//   out_valid  out  1      out_id holds a request
//   out_id     out  3      presented request index
//   out_ready  in   1      consumer accepts when out_valid & out_ready
//   pend_o     out  8      pending register
//   ovf_o      out  1      sticky: edge arrived on an already pending line
//   ovf_clr_i  in   1      clears ovf_o (a simultaneous set wins)
//   svc_cnt_o  out  CNT_W  accepted request count, wrapping
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | nothing presented; picks the next eligible request if any
// ST_PRESENT | out_id presented and frozen until the consumer accepts it
module req_dispatch_8
    import req_dispatch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic             out_valid,
    output logic [ID_W-1:0]  out_id,
    input  logic             out_ready,
    output logic [N_REQ-1:0] pend_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] svc_cnt_o
);

    state_t           state;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pend;
    logic [N_REQ-1:0] req_edge;
    logic [N_REQ-1:0] acc_clr;
    logic [N_REQ-1:0] eligible;
    logic [ID_W-1:0]  sel_id;
    logic             sel_any;
    logic             fire;

    assign req_edge = req_i & ~req_q;
    assign fire     = out_valid & out_ready;
    assign acc_clr  = fire ? (N_REQ'(1) << out_id) : '0;
    assign eligible = pend & ~mask_i;
    assign pend_o   = pend;

    prio_enc8 u_prio (
        .eligible_i (eligible),
        .id_o       (sel_id),
        .any_o      (sel_any)
    );

    // Edge capture and overflow; a new edge beats an acceptance clear on the same bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q <= '0;
            pend  <= '0;
            ovf_o <= 1'b0;
        end else begin
            req_q <= req_i;
            pend  <= req_edge | (pend & ~acc_clr);
            if (|(req_edge & pend)) begin
                ovf_o <= 1'b1;
            end else if (ovf_clr_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_id    <= '0;
            svc_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        out_id    <= sel_id;
                        out_valid <= 1'b1;
                        state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        svc_cnt_o <= svc_cnt_o + CNT_W'(1);
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
